// File: rtl/knap_item_update_if.sv
// Single-port DP-table memory bus between the knapsack item sequencer (master)
// and the word memory (slave). Read data is registered: it returns one cycle after rd_en.
interface knap_item_update_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, rd_en, wr_en, wdata, input rdata);
    modport slave  (input addr, rd_en, wr_en, wdata, output rdata);
endinterface

// File: rtl/knap_item_update.sv
// Applies one 0/1-knapsack item to the DP table: dp[w] = max(dp[w], dp[w-wt] + val), w = cap..wt.
// Optional macro KNAP_SAT_EN: saturate the candidate sum instead of wrapping it.
module knap_item_update #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int CAP_MAX = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [6:0]        item_wt,
    input  logic [DATA_W-1:0] item_val,
    input  logic [6:0]        cap,
    output logic              busy,
    output logic              done,
    output logic [6:0]        updated_cnt,
    knap_item_update_if.master mem
);

    typedef enum logic [2:0] {IDLE, RD_CUR, RD_PRV, CALC, WR, DONE} state_t;

    state_t            state, state_nxt;
    logic [6:0]        w, w_nxt;
    logic [6:0]        cnt_nxt;
    logic [6:0]        wt_q;
    logic [DATA_W-1:0] val_q;
    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_c;
    logic [DATA_W-1:0] prev_c;
    logic              last;
    logic              reject;

    function automatic logic [DATA_W-1:0] add_item(input logic [DATA_W-1:0] prev,
                                                   input logic [DATA_W-1:0] val);
`ifdef KNAP_SAT_EN
        logic [DATA_W:0] s;
        s = {1'b0, prev} + {1'b0, val};
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
`else
        return prev + val;
`endif
    endfunction

    assign last   = (w == wt_q);
    assign reject = (item_wt == 7'd0) || (cap == 7'd0) ||
                    (int'(cap) > CAP_MAX) || (item_wt > cap);
    // dp[0] is never stored; it is implicitly zero
    assign prev_c = last ? '0 : mem.rdata;
    assign sum_c  = add_item(prev_c, val_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            w           <= '0;
            updated_cnt <= '0;
        end else begin
            state       <= state_nxt;
            w           <= w_nxt;
            updated_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            wt_q  <= item_wt;
            val_q <= item_val;
        end
        if (state == RD_PRV) cur_q <= mem.rdata;
        if (state == CALC)   sum_q <= sum_c;
    end

    always_comb begin
        state_nxt = state;
        w_nxt     = w;
        cnt_nxt   = updated_cnt;
        busy      = 1'b0;
        done      = 1'b0;
        mem.addr  = '0;
        mem.rd_en = 1'b0;
        mem.wr_en = 1'b0;
        mem.wdata = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt = '0;
                    if (reject) begin
                        state_nxt = DONE;
                    end else begin
                        w_nxt     = cap;
                        state_nxt = RD_CUR;
                    end
                end
            end
            RD_CUR: begin
                busy      = 1'b1;
                mem.addr  = ADDR_W'(w);
                mem.rd_en = 1'b1;
                state_nxt = RD_PRV;
            end
            RD_PRV: begin
                busy = 1'b1;
                if (!last) begin
                    mem.addr  = ADDR_W'(w - wt_q);
                    mem.rd_en = 1'b1;
                end
                state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (sum_c > cur_q) begin
                    state_nxt = WR;
                end else if (last) begin
                    state_nxt = DONE;
                end else begin
                    w_nxt     = w - 7'd1;
                    state_nxt = RD_CUR;
                end
            end
            WR: begin
                busy      = 1'b1;
                mem.addr  = ADDR_W'(w);
                mem.wr_en = 1'b1;
                mem.wdata = sum_q;
                cnt_nxt   = updated_cnt + 7'd1;
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    w_nxt     = w - 7'd1;
                    state_nxt = RD_CUR;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_knap_item_update.sv
// Directed bench for knap_item_update with a registered-read behavioural word memory.
module tb_knap_item_update;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  item_wt;
    logic [31:0] item_val;
    logic [6:0]  cap;
    logic        busy;
    logic        done;
    logic [6:0]  updated_cnt;

    int checks;
    int failures;
    int strobe_cnt;
    int overlap_cnt;

    logic [31:0] arr [0:127];

    knap_item_update_if #(.ADDR_W(16), .DATA_W(32)) mem ();

    knap_item_update dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .item_wt     (item_wt),
        .item_val    (item_val),
        .cap         (cap),
        .busy        (busy),
        .done        (done),
        .updated_cnt (updated_cnt),
        .mem         (mem.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem.wr_en && mem.addr < 16'd128) arr[mem.addr[6:0]] <= mem.wdata;
        if (mem.rd_en && mem.addr < 16'd128) mem.rdata <= arr[mem.addr[6:0]];
        else                                 mem.rdata <= 32'd0;
    end

    always @(negedge clk) begin
        if (mem.rd_en || mem.wr_en) strobe_cnt++;
        if (mem.rd_en && mem.wr_en) overlap_cnt++;
    end

    task automatic clear_table();
        for (int i = 0; i < 128; i++) arr[i] = 32'd0;
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that leaves DONE.
    task automatic run_item(input logic [6:0] wt, input logic [31:0] val, input logic [6:0] c,
                            input int restart_at, output int dcyc);
        item_wt  = wt;
        item_val = val;
        cap      = c;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcyc  = 1;
        while (done !== 1'b1 && dcyc < 1000) begin
            if (dcyc == restart_at) begin
                start    = 1'b1;
                item_wt  = 7'd1;
                item_val = 32'd99;
                cap      = 7'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            dcyc++;
        end
        start = 1'b0;
        if (done !== 1'b1) dcyc = -1;
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, done, updated_cnt, mem.addr, mem.rd_en, mem.wr_en, mem.wdata} !== '0) begin
            failures++;
            $display("FAIL %s: busy=%0b done=%0b cnt=%0d addr=%0d rd=%0b wr=%0b wdata=%h, required all 0",
                     name, busy, done, updated_cnt, mem.addr, mem.rd_en, mem.wr_en, mem.wdata);
        end
    endtask

    task automatic check_scen1(input string name, input int dcyc);
        logic [31:0] exp;
        checks++;
        if (dcyc != 33) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d, required 33", name, dcyc);
        end
        checks++;
        if (updated_cnt !== 7'd8) begin
            failures++;
            $display("FAIL %s_cnt: got %0d, required 8", name, updated_cnt);
        end
        for (int i = 1; i <= 10; i++) begin
            exp = (i >= 3) ? 32'd5 : 32'd0;
            checks++;
            if (arr[i] !== exp) begin
                failures++;
                $display("FAIL %s_dp[%0d]: got %h, required %h", name, i, arr[i], exp);
            end
        end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset_state");
    endtask

    task automatic test_first_item();
        int dcyc;
        clear_table();
        run_item(7'd3, 32'd5, 7'd10, -1, dcyc);
        check_scen1("item1", dcyc);
    endtask

    task automatic test_second_item();
        int dcyc;
        logic [31:0] exp;
        run_item(7'd4, 32'd7, 7'd10, -1, dcyc);
        checks++;
        if (dcyc != 29) begin
            failures++;
            $display("FAIL item2_done_cycle: got %0d, required 29", dcyc);
        end
        checks++;
        if (updated_cnt !== 7'd7) begin
            failures++;
            $display("FAIL item2_cnt: got %0d, required 7", updated_cnt);
        end
        for (int i = 1; i <= 10; i++) begin
            exp = (i >= 7) ? 32'd12 : (i >= 4) ? 32'd7 : (i == 3) ? 32'd5 : 32'd0;
            checks++;
            if (arr[i] !== exp) begin
                failures++;
                $display("FAIL item2_dp[%0d]: got %h, required %h", i, arr[i], exp);
            end
        end
    endtask

    task automatic test_reject();
        int dcyc;
        int s0;
        logic [6:0] wts [3];
        logic [6:0] caps [3];
        wts  = '{7'd0, 7'd11, 7'd3};
        caps = '{7'd10, 7'd10, 7'd65};
        for (int k = 0; k < 3; k++) begin
            s0 = strobe_cnt;
            run_item(wts[k], 32'd9, caps[k], -1, dcyc);
            checks++;
            if (dcyc != 1) begin
                failures++;
                $display("FAIL reject%0d_done_cycle: got %0d, required 1", k, dcyc);
            end
            checks++;
            if (updated_cnt !== 7'd0) begin
                failures++;
                $display("FAIL reject%0d_cnt: got %0d, required 0", k, updated_cnt);
            end
            checks++;
            if (strobe_cnt != s0) begin
                failures++;
                $display("FAIL reject%0d_strobes: got %0d, required 0", k, strobe_cnt - s0);
            end
        end
    endtask

    task automatic test_overflow();
        int dcyc;
        logic [31:0] exp2;
`ifdef KNAP_SAT_EN
        exp2 = 32'hFFFF_FFFF;
`else
        exp2 = 32'h0000_0010;
`endif
        clear_table();
        arr[1] = 32'hFFFF_FFF0;
        run_item(7'd1, 32'h20, 7'd2, -1, dcyc);
        checks++;
        if (arr[2] !== exp2) begin
            failures++;
            $display("FAIL ovf_dp2: got %h, required %h", arr[2], exp2);
        end
        checks++;
        if (arr[1] !== 32'hFFFF_FFF0) begin
            failures++;
            $display("FAIL ovf_dp1: got %h, required fffffff0", arr[1]);
        end
        checks++;
        if (updated_cnt !== 7'd1) begin
            failures++;
            $display("FAIL ovf_cnt: got %0d, required 1", updated_cnt);
        end
        checks++;
        if (dcyc != 8) begin
            failures++;
            $display("FAIL ovf_done_cycle: got %0d, required 8", dcyc);
        end
    endtask

    task automatic test_back_to_back();
        int dcyc;
        clear_table();
        run_item(7'd3, 32'd5, 7'd10, 5, dcyc);
        check_scen1("restart", dcyc);
    endtask

    task automatic test_reset_mid_write();
        int n;
        int dcyc;
        clear_table();
        item_wt  = 7'd3;
        item_val = 32'd5;
        cap      = 7'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (mem.wr_en !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mem.wr_en !== 1'b1) begin
            failures++;
            $display("FAIL rstwr_reach_write: wr_en=%0b, required 1", mem.wr_en);
        end
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rstwr_async");
        @(posedge clk); #1;
        check_idle_outputs("rstwr_held");
        checks++;
        if (arr[10] !== 32'd0) begin
            failures++;
            $display("FAIL rstwr_no_partial_write: dp[10]=%h, required 0", arr[10]);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_table();
        run_item(7'd3, 32'd5, 7'd10, -1, dcyc);
        check_scen1("after_rst", dcyc);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        strobe_cnt  = 0;
        overlap_cnt = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        item_wt     = '0;
        item_val    = '0;
        cap         = '0;
        clear_table();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_first_item();
        test_second_item();
        test_reject();
        test_overflow();
        test_back_to_back();
        test_reset_mid_write();
        checks++;
        if (overlap_cnt != 0) begin
            failures++;
            $display("FAIL strobe_overlap: got %0d cycles, required 0", overlap_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
